// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and error codes for the UART frame decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CHK   = 3'd3,
    ABORT = 3'd4
  } t_frm_state;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;
endpackage

`default_nettype wire

// File: rtl/axis_skid2.sv
// ============================================================================
// Module   : axis_skid2
// Brief    : 2-entry AXIS buffer, {tuser,tlast,tdata} payload, free count out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_skid2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [9:0] i_push_data,
  input  logic       i_pop_ready,
  output logic       o_valid,
  output logic [9:0] o_data,
  output logic [1:0] o_free,
  output logic [1:0] o_free_next
);
  logic [1:0] r_cnt;
  logic [9:0] r_d0;
  logic [9:0] r_d1;
  logic       w_pop;
  logic       w_push;
  logic [1:0] w_cnt_pop;
  logic [1:0] w_cnt_next;

  always_comb begin
    w_pop       = (r_cnt != 2'd0) && i_pop_ready;
    w_cnt_pop   = r_cnt - {1'b0, w_pop};
    w_push      = i_push && (w_cnt_pop != 2'd2);
    w_cnt_next  = w_cnt_pop + {1'b0, w_push};
    o_free      = 2'd2 - r_cnt;
    o_free_next = 2'd2 - w_cnt_next;
    o_valid     = (r_cnt != 2'd0);
    o_data      = r_d0;
  end

  // Head entry only changes on a pop or a push into an empty buffer, so the
  // presented beat stays stable while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 2'd0;
      r_d0  <= 10'd0;
      r_d1  <= 10'd0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_pop) r_d0 <= r_d1;
      if (w_push) begin
        if (w_cnt_pop == 2'd0) r_d0 <= i_push_data;
        else                   r_d1 <= i_push_data;
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/uart_frame_decoder.sv
// ============================================================================
// Module   : uart_frame_decoder
// Brief    : Extracts SOF/LEN/payload/CHK frames from a byte stream to AXIS.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE     = 8'hA5,
  parameter int unsigned MAX_LEN      = 64,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_s_axis_tvalid,
  input  logic [7:0]  i_s_axis_tdata,
  output logic        o_s_axis_tready,
  input  logic        i_m_axis_tready,
  output logic        o_m_axis_tvalid,
  output logic [7:0]  o_m_axis_tdata,
  output logic        o_m_axis_tlast,
  output logic        o_m_axis_tuser,
  output logic        o_frm_ok,
  output logic        o_frm_err,
  output logic [1:0]  o_err_code,
  output logic [15:0] o_drop_cnt
);
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]    c_max_len  = 8'(MAX_LEN);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT_CLKS - 1);

  t_frm_state  r_state;
  logic [7:0]  r_rem;
  logic [7:0]  r_chk;
  logic [7:0]  r_hold;
  logic        r_hold_full;
  logic [TW-1:0] r_tmo;
  logic [15:0] r_drop_cnt;
  logic        r_frm_ok;
  logic        r_frm_err;
  logic [1:0]  r_err_code;
  logic        r_s_tready;

  logic        w_push;
  logic [9:0]  w_push_data;
  logic        w_skid_valid;
  logic [9:0]  w_skid_data;
  logic [1:0]  w_free;
  logic [1:0]  w_free_next;
  logic        w_abort_done;
  logic        w_hunt;

  always_comb begin
    w_push       = 1'b0;
    w_push_data  = 10'd0;
    w_abort_done = (r_state == ABORT) && (!r_hold_full || (w_free != 2'd0));
    w_hunt       = (r_state == IDLE) || w_abort_done;
    case (r_state)
      DATA: if (i_s_axis_tvalid && r_hold_full) begin
        w_push      = 1'b1;
        w_push_data = {2'b00, r_hold};
      end
      CHK: if (i_s_axis_tvalid) begin
        w_push      = 1'b1;
        w_push_data = {(i_s_axis_tdata != r_chk), 1'b1, r_hold};
      end
      ABORT: if (r_hold_full && (w_free != 2'd0)) begin
        w_push      = 1'b1;
        w_push_data = {2'b11, r_hold};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_rem       <= 8'd0;
      r_chk       <= 8'd0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_tmo       <= '0;
      r_drop_cnt  <= 16'd0;
      r_frm_ok    <= 1'b0;
      r_frm_err   <= 1'b0;
      r_err_code  <= 2'd0;
      r_s_tready  <= 1'b1;
    end else begin
      r_frm_ok   <= 1'b0;
      r_frm_err  <= 1'b0;
      r_s_tready <= (w_free_next == 2'd2);

      if (r_state == LEN || r_state == DATA || r_state == CHK) begin
        if (i_s_axis_tvalid)            r_tmo <= '0;
        else if (r_tmo == c_tmo_last)   r_state <= ABORT;
        else                            r_tmo <= r_tmo + 1'b1;
      end else begin
        r_tmo <= '0;
      end

      case (r_state)
        LEN: if (i_s_axis_tvalid) begin
          if (i_s_axis_tdata == 8'd0 || i_s_axis_tdata > c_max_len) begin
            r_frm_err  <= 1'b1;
            r_err_code <= ERR_LEN;
            r_state    <= IDLE;
          end else begin
            r_rem   <= i_s_axis_tdata;
            r_chk   <= i_s_axis_tdata;
            r_state <= DATA;
          end
        end
        DATA: if (i_s_axis_tvalid) begin
          r_chk       <= r_chk ^ i_s_axis_tdata;
          r_hold      <= i_s_axis_tdata;
          r_hold_full <= 1'b1;
          r_rem       <= r_rem - 8'd1;
          if (r_rem == 8'd1) r_state <= CHK;
        end
        CHK: if (i_s_axis_tvalid) begin
          r_hold_full <= 1'b0;
          r_state     <= IDLE;
          if (i_s_axis_tdata == r_chk) begin
            r_frm_ok <= 1'b1;
          end else begin
            r_frm_err  <= 1'b1;
            r_err_code <= ERR_CHK;
          end
        end
        ABORT: if (w_abort_done) begin
          r_hold_full <= 1'b0;
          r_frm_err   <= 1'b1;
          r_err_code  <= ERR_TMO;
          r_state     <= IDLE;
        end
        default: ;
      endcase

      // Hunting for SOF; a completing ABORT also consumes its input beat here.
      if (w_hunt && i_s_axis_tvalid) begin
        if (i_s_axis_tdata == SOF_BYTE) r_state <= LEN;
        else if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  axis_skid2 u_skid (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop_ready (i_m_axis_tready),
    .o_valid     (w_skid_valid),
    .o_data      (w_skid_data),
    .o_free      (w_free),
    .o_free_next (w_free_next)
  );

  assign o_s_axis_tready = r_s_tready;
  assign o_m_axis_tvalid = w_skid_valid;
  assign o_m_axis_tdata  = w_skid_data[7:0];
  assign o_m_axis_tlast  = w_skid_data[8];
  assign o_m_axis_tuser  = w_skid_data[9];
  assign o_frm_ok        = r_frm_ok;
  assign o_frm_err       = r_frm_err;
  assign o_err_code      = r_err_code;
  assign o_drop_cnt      = r_drop_cnt;
endmodule

`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
// ============================================================================
// Module   : tb_uart_frame_decoder
// Brief    : Randomised scoreboard bench for uart_frame_decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_frame_decoder;
  localparam int TMO  = 300;
  localparam int MAXL = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_s_axis_tvalid = 1'b0;
  logic [7:0]  i_s_axis_tdata = 8'd0;
  logic        o_s_axis_tready;
  logic        i_m_axis_tready = 1'b1;
  logic        o_m_axis_tvalid;
  logic [7:0]  o_m_axis_tdata;
  logic        o_m_axis_tlast;
  logic        o_m_axis_tuser;
  logic        o_frm_ok;
  logic        o_frm_err;
  logic [1:0]  o_err_code;
  logic [15:0] o_drop_cnt;

  uart_frame_decoder #(
    .SOF_BYTE     (8'hA5),
    .MAX_LEN      (MAXL),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_s_axis_tvalid (i_s_axis_tvalid),
    .i_s_axis_tdata  (i_s_axis_tdata),
    .o_s_axis_tready (o_s_axis_tready),
    .i_m_axis_tready (i_m_axis_tready),
    .o_m_axis_tvalid (o_m_axis_tvalid),
    .o_m_axis_tdata  (o_m_axis_tdata),
    .o_m_axis_tlast  (o_m_axis_tlast),
    .o_m_axis_tuser  (o_m_axis_tuser),
    .o_frm_ok        (o_frm_ok),
    .o_frm_err       (o_frm_err),
    .o_err_code      (o_err_code),
    .o_drop_cnt      (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] in_q[$];
  logic [7:0] seq[$];
  logic [9:0] exp_beats[$];   // {tuser, tlast, tdata}
  logic [2:0] exp_ev[$];      // {ok, err_code}
  int   exp_drop = 0;
  logic stall    = 1'b0;
  logic saw_low  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_bytes(input logic [7:0] b[8], input int n);
    for (int k = 0; k < n; k++) seq.push_back(b[k]);
  endtask

  // Reference model: parses a complete byte sequence by the frame rules.
  task automatic send_seq();
    int i, len;
    logic [7:0] x;
    i = 0;
    while (i < seq.size()) begin
      if (seq[i] != 8'hA5) begin
        exp_drop++;
        i++;
      end else begin
        len = int'(seq[i+1]);
        i += 2;
        if (len == 0 || len > MAXL) begin
          exp_ev.push_back(3'b001);
        end else begin
          x = 8'(len);
          for (int k = 0; k < len; k++) x ^= seq[i+k];
          for (int k = 0; k < len; k++)
            exp_beats.push_back({(k == len-1) && (x != seq[i+len]), k == len-1, seq[i+k]});
          exp_ev.push_back((x == seq[i+len]) ? 3'b100 : 3'b010);
          i += len + 1;
        end
      end
    end
    foreach (seq[k]) in_q.push_back(seq[k]);
    seq.delete();
  endtask

  task automatic drain();
    int n = 0;
    while ((in_q.size() != 0 || exp_beats.size() != 0 || exp_ev.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got beats=%0d events=%0d expected 0", exp_beats.size(), exp_ev.size());
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_tvalid"}, 32'(o_m_axis_tvalid), 32'd0);
    check({tag, "_tdata"},  32'(o_m_axis_tdata),  32'd0);
    check({tag, "_tlast"},  32'(o_m_axis_tlast),  32'd0);
    check({tag, "_tuser"},  32'(o_m_axis_tuser),  32'd0);
    check({tag, "_ok"},     32'(o_frm_ok),        32'd0);
    check({tag, "_err"},    32'(o_frm_err),       32'd0);
    check({tag, "_code"},   32'(o_err_code),      32'd0);
    check({tag, "_drop"},   32'(o_drop_cnt),      32'd0);
    check({tag, "_sready"}, 32'(o_s_axis_tready), 32'd1);
  endtask

  // Upstream driver: models one cycle of FIFO read latency on s_tready.
  initial begin : driver
    logic tr_prev;
    tr_prev = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && tr_prev && in_q.size() != 0 && $urandom_range(0, 3) != 0) begin
        i_s_axis_tvalid = 1'b1;
        i_s_axis_tdata  = in_q.pop_front();
      end else begin
        i_s_axis_tvalid = 1'b0;
      end
      tr_prev = o_s_axis_tready;
    end
  end

  always @(posedge clk) begin
    #1;
    i_m_axis_tready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (stall && !o_s_axis_tready) saw_low = 1'b1;
    if (!rst) begin
      if (o_m_axis_tvalid && i_m_axis_tready) begin
        if (exp_beats.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got %0h expected none", {o_m_axis_tuser, o_m_axis_tlast, o_m_axis_tdata});
        end else begin
          check("beat", 32'({o_m_axis_tuser, o_m_axis_tlast, o_m_axis_tdata}), 32'(exp_beats.pop_front()));
        end
      end
      if (o_frm_ok || o_frm_err) begin
        if (exp_ev.size() == 0) begin
          total++;
          bad++;
          $display("FAIL event_unexpected: got ok=%0d err=%0d expected none", o_frm_ok, o_frm_err);
        end else begin
          logic [2:0] e;
          e = exp_ev.pop_front();
          check("ev_ok", 32'(o_frm_ok), 32'(e[2]));
          if (!e[2]) check("err_code", 32'(o_err_code), 32'(e[1:0]));
        end
      end
    end
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;

    add_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h00, 8'h00}, 6);
    send_seq(); drain();
    check("drop_good", 32'(o_drop_cnt), 32'(exp_drop));

    add_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04, 8'h00, 8'h00}, 6);
    send_seq(); drain();

    add_bytes('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F, 8'h00, 8'h00}, 6);
    send_seq(); drain();
    check("drop_two", 32'(o_drop_cnt), 32'(exp_drop));

    add_bytes('{8'hA5, 8'h00, 8'hA5, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    send_seq(); drain();

    // Timeout with a held byte, then a clean frame.
    in_q.push_back(8'hA5); in_q.push_back(8'h02); in_q.push_back(8'h10);
    exp_beats.push_back(10'h310);
    exp_ev.push_back(3'b011);
    drain();
    add_bytes('{8'hA5, 8'h01, 8'h55, 8'h54, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    send_seq(); drain();

    // Timeout with an empty hold register.
    in_q.push_back(8'hA5); in_q.push_back(8'h02);
    exp_ev.push_back(3'b011);
    drain();

    // Downstream stall mid-frame.
    seq.push_back(8'hA5); seq.push_back(8'd30);
    begin
      logic [7:0] x;
      x = 8'd30;
      for (int k = 0; k < 30; k++) begin
        seq.push_back(8'($urandom_range(0, 255)));
        x ^= seq[seq.size()-1];
      end
      seq.push_back(x);
    end
    send_seq();
    repeat (6) @(posedge clk);
    stall = 1'b1;
    repeat (20) @(posedge clk);
    stall = 1'b0;
    drain();
    check("s_tready_fell", 32'(saw_low), 32'd1);

    // Randomised frames.
    for (int f = 0; f < 40; f++) begin
      int g, kind, len;
      logic [7:0] x, b;
      g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) begin
        b = 8'($urandom_range(0, 254));
        if (b >= 8'hA5) b = b + 8'd1;
        seq.push_back(b);
      end
      kind = $urandom_range(0, 9);
      seq.push_back(8'hA5);
      if (kind >= 8) begin
        seq.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(65, 255)));
      end else begin
        len = $urandom_range(1, MAXL);
        seq.push_back(8'(len));
        x = 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 255));
          seq.push_back(b);
          x ^= b;
        end
        seq.push_back((kind >= 6) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
      end
      send_seq();
    end
    drain();
    check("drop_random", 32'(o_drop_cnt), 32'(exp_drop));

    // Reset mid-frame: two beats already out, third byte held, then reset.
    in_q.push_back(8'hA5); in_q.push_back(8'h04);
    in_q.push_back(8'h11); in_q.push_back(8'h22); in_q.push_back(8'h33);
    exp_beats.push_back(10'h011);
    exp_beats.push_back(10'h022);
    drain();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    reset_checks("midrst");
    rst = 1'b0;
    exp_drop = 0;
    add_bytes('{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h9B, 8'h00, 8'h00, 8'h00}, 5);
    send_seq(); drain();
    check("drop_after_rst", 32'(o_drop_cnt), 32'(exp_drop));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
